mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Round-robin scheduler sharing one pipelined mult_gen_0 multiplier among NUM_REQ filter sections
//  (filtr_a-style notch stages), so that a cascade does not need two DSP multipliers per section.
//  Each cycle it grants at most one requester and drives that requester's operands into the multiplier.
//  It tags the request through the multiplier pipeline and returns the product to the issuing requester.
// PARAMETERS
//  NUM_REQ    2   number of requesting sections, 2..8
//  COEF_SIZE  25  width of operand A (signed)
//  DATA_SIZE  25  width of operand B (signed)
//  MULT_LAT   1   multiplier latency in clk cycles, 1..4; must match the mult_gen_0 configuration
// PORTS
//  clk        in   1                      single system clock, rising edge
//  reset_n    in   1                      reset, synchronous, active-low
//  req        in   NUM_REQ                per-requester multiply request; held until its gnt bit is high
//  a_in       in   NUM_REQ*COEF_SIZE      signed operand A, requester i in bits [i*COEF_SIZE +: COEF_SIZE]
//  b_in       in   NUM_REQ*DATA_SIZE      signed operand B, packed the same way as a_in
//  gnt        out  NUM_REQ                one-hot grant (combinational); operands are consumed this cycle
//  res_valid  out  NUM_REQ                one-hot, 1-cycle pulse: product for requester i is on res_out
//  res_out    out  COEF_SIZE+DATA_SIZE    signed full-width product, broadcast to all requesters
//  lock       in   NUM_REQ                present only with MULT_ARB_LOCK_EN defined
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge):
//    - rr_ptr <= 0.
//    - All tag-pipeline valid bits <= 0, so res_valid=0 from the next cycle.
//    - res_out <= 0.
//    - While reset_n=0, gnt is forced to 0 combinationally.
//  - Grant selection: search req starting at index rr_ptr and wrap modulo NUM_REQ; the first set bit wins.
//    If req==0 then gnt=0.
//  - Operands: the multiplier A/B inputs take the winner's a_in/b_in slices. With no grant they are 0.
//  - Pointer update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
//  - Tag pipeline: MULT_LAT stages of {valid, idx[$clog2(NUM_REQ)-1:0]}.
//    - Stage 0 loads {|gnt, g} at every edge.
//    - res_valid[idx] = valid of the last stage.
//    - res_out = multiplier P.
//    - Latency is exactly MULT_LAT cycles from the gnt cycle to the res_valid cycle.
//  - Throughput: one grant per cycle.
//    - A single requester holding req high is granted every cycle.
//    - K active requesters are each granted every K cycles, with no starvation.
//  - If a requester drops req before being granted, nothing is issued and rr_ptr does not change.
//  - Arithmetic: full-precision signed product, COEF_SIZE+DATA_SIZE bits.
//    The arbiter does no shift or truncation; requesters apply >>>(COEF_SIZE-2) themselves.
//  - Reset mid-operation: in-flight products are discarded and no res_valid is emitted for them.
//    Requesters restart their sample FSM from IDLE.
//  - req bits with index >= NUM_REQ do not exist; NUM_REQ=1 degenerates to a pass-through with gnt=req.
// CONFIGURATION
//  MULT_ARB_LOCK_EN defined:
//    - Adds the lock input.
//    - If the current winner g has lock[g]=1 at the grant edge, it becomes the locked owner:
//      gnt stays on g every cycle while req[g]=1 and lock[g]=1. Other requests wait.
//    - rr_ptr advances only when g releases, i.e. at its first grant with lock[g]=0, or when req[g]=0.
//    - Use case: back-to-back multiplies within one filter sample, S1..S3 of a section.
//  MULT_ARB_LOCK_EN undefined: no lock port; pure round-robin as above.
// STRUCTURE
//  - Package mult_arb_pkg: localparam IDX_W=$clog2(NUM_REQ); function rr_pick(req, ptr) returning the winner index.
//  - Sub-module mult_gen_0 is instantiated inside this block; the arbiter is the multiplier's only driver.
//  - The tag pipeline is a generate loop of MULT_LAT registers; no further sub-modules.
// TESTING
//  T1 reset: hold reset_n=0 for 3 clk with req=2'b11 -> gnt=0 and res_valid=0.
//     After release, first gnt=2'b01 (ptr=0).
//  T2 single requester: NUM_REQ=2, req=2'b10, a=3, b=-5 every cycle, MULT_LAT=1.
//     -> gnt=2'b10 every cycle; res_valid=2'b10 one cycle later; res_out=-15.
//  T3 contention: req=2'b11 held, a0=2, b0=7, a1=-4, b1=4.
//     -> gnt alternates 01,10,01...; results alternate 14 and -16, each tagged to its requester.
//  T4 latency: MULT_LAT=3, one pulse req[0] with a=2^23, b=2.
//     -> res_valid[0] exactly 3 cycles after gnt; res_out=2^24.
//  T5 reset mid-flight: grant at cycle n, reset_n=0 at n+1 (MULT_LAT=3).
//     -> no res_valid for that request in any later cycle.
//  T6 lock (MULT_ARB_LOCK_EN): req=2'b11, lock[0]=1 for 3 grants.
//     -> gnt=01,01,01, then 10 after lock[0] falls.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: requester limits and the round-robin pick.
// Optional feature macro used by this slice: MULT_ARB_LOCK_EN.
package mult_arb_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  // Index width for a given requester count; a single requester still needs one tag bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req, searching upward from ptr and wrapping modulo n.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [MAX_IDX_W-1:0] ptr,
                                                   input int unsigned n);
    logic [MAX_IDX_W-1:0] win;
    logic                 found;
    int unsigned          k;
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n && !found) begin
        k = (ptr + i) % n;
        if (req[k[MAX_IDX_W-1:0]]) begin
          win   = k[MAX_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// Behavioural stand-in for the mult_gen_0 IP: signed A*B, LATENCY register stages, synchronous clear.
module mult_gen_0 #(
  parameter int unsigned A_WIDTH = 25,
  parameter int unsigned B_WIDTH = 25,
  parameter int unsigned LATENCY = 1
) (
  input  logic                              CLK,
  input  logic                              SCLR,
  input  logic signed [A_WIDTH-1:0]         A,
  input  logic signed [B_WIDTH-1:0]         B,
  output logic signed [A_WIDTH+B_WIDTH-1:0] P
);

  logic signed [A_WIDTH+B_WIDTH-1:0] pipe [LATENCY];

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= A * B;
      for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign P = pipe[LATENCY-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined mult_gen_0 among NUM_REQ requesters, results tagged back.
// Define MULT_ARB_LOCK_EN to add the lock input (winner may hold the multiplier for back-to-back ops).
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned COEF_SIZE = 25,
  parameter int unsigned DATA_SIZE = 25,
  parameter int unsigned MULT_LAT  = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*COEF_SIZE-1:0]        a_in,
  input  logic [NUM_REQ*DATA_SIZE-1:0]        b_in,
`ifdef MULT_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                  lock,
`endif
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  res_valid,
  output logic signed [COEF_SIZE+DATA_SIZE-1:0] res_out
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [IDX_W-1:0]              rr_ptr;
  logic [IDX_W-1:0]              win;
  logic [IDX_W-1:0]              ptr_nxt;
  logic [MAX_REQ-1:0]            req_ext;
  logic                          any_gnt;
  logic signed [COEF_SIZE-1:0]   mult_a;
  logic signed [DATA_SIZE-1:0]   mult_b;

  logic [MULT_LAT-1:0]            tag_vld;
  logic [MULT_LAT-1:0][IDX_W-1:0] tag_idx;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    win     = IDX_W'(rr_pick(req_ext, MAX_IDX_W'(rr_ptr), NUM_REQ));
    any_gnt = reset_n && (|req);
  end

  always_comb begin
    gnt    = '0;
    mult_a = '0;
    mult_b = '0;
    if (any_gnt) begin
      gnt[win] = 1'b1;
      mult_a   = a_in[win*COEF_SIZE +: COEF_SIZE];
      mult_b   = b_in[win*DATA_SIZE +: DATA_SIZE];
    end
  end

  // A locked winner parks the pointer on itself so the next search starts (and ends) there.
  always_comb begin
    ptr_nxt = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef MULT_ARB_LOCK_EN
    if (lock[win]) ptr_nxt = win;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= ptr_nxt;
    end
  end

  for (genvar s = 0; s < MULT_LAT; s++) begin : g_tag
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        tag_vld[s] <= 1'b0;
        tag_idx[s] <= '0;
      end else if (s == 0) begin
        tag_vld[s] <= any_gnt;
        tag_idx[s] <= win;
      end else begin
        tag_vld[s] <= tag_vld[(s == 0) ? 0 : s-1];
        tag_idx[s] <= tag_idx[(s == 0) ? 0 : s-1];
      end
    end
  end

  always_comb begin
    res_valid = '0;
    if (tag_vld[MULT_LAT-1]) res_valid[tag_idx[MULT_LAT-1]] = 1'b1;
  end

  mult_gen_0 #(
    .A_WIDTH (COEF_SIZE),
    .B_WIDTH (DATA_SIZE),
    .LATENCY (MULT_LAT)
  ) u_mult (
    .CLK  (clk),
    .SCLR (!reset_n),
    .A    (mult_a),
    .B    (mult_b),
    .P    (res_out)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: table of cycle vectors plus reset, latency and lock sequences.
module tb_mult_share_arbiter;

  logic               clk;
  logic               reset_n;
  logic [1:0]         req;
  logic signed [24:0] a0, b0, a1, b1;
  logic [49:0]        a_in, b_in;
  logic [1:0]         lock;
  logic [1:0]         gnt1, gnt3, rv1, rv3;
  logic signed [49:0] res1, res3;

  int n_chk;
  int n_fail;

  assign a_in = {a1, a0};
  assign b_in = {b1, b0};

  mult_share_arbiter #(.NUM_REQ(2), .COEF_SIZE(25), .DATA_SIZE(25), .MULT_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
`ifdef MULT_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt1), .res_valid(rv1), .res_out(res1)
  );

  mult_share_arbiter #(.NUM_REQ(2), .COEF_SIZE(25), .DATA_SIZE(25), .MULT_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
`ifdef MULT_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt3), .res_valid(rv3), .res_out(res3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         req;
    logic signed [24:0] a0, b0, a1, b1;
    logic [1:0]         gnt;
    logic [1:0]         rv;
    logic signed [63:0] res;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [1:0] r, input int x0, input int y0, input int x1,
                              input int y1, input logic [1:0] g, input logic [1:0] v,
                              input logic signed [63:0] p);
    vec_t t;
    t.req = r;  t.a0 = 25'(x0); t.b0 = 25'(y0); t.a1 = 25'(x1); t.b1 = 25'(y1);
    t.gnt = g;  t.rv = v;       t.res = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; req = 2'b11; lock = 2'b00;
    a0 = 25'sd2; b0 = 25'sd7; a1 = 25'sd3; b1 = -25'sd5;

    // Rows are consecutive cycles; rv/res reflect the grant of the previous row (MULT_LAT=1).
    tbl[0]  = mk(2'b10, 0, 0, 3, -5, 2'b10, 2'b00, 0);
    tbl[1]  = mk(2'b10, 0, 0, 3, -5, 2'b10, 2'b10, -15);
    tbl[2]  = mk(2'b11, 2, 7, -4, 4, 2'b01, 2'b10, -15);
    tbl[3]  = mk(2'b11, 2, 7, -4, 4, 2'b10, 2'b01, 14);
    tbl[4]  = mk(2'b11, 2, 7, -4, 4, 2'b01, 2'b10, -16);
    tbl[5]  = mk(2'b00, 2, 7, -4, 4, 2'b00, 2'b01, 14);
    tbl[6]  = mk(2'b01, 2, 7, -4, 4, 2'b01, 2'b00, 0);
    tbl[7]  = mk(2'b00, 2, 7, -4, 4, 2'b00, 2'b01, 14);
    tbl[8]  = mk(2'b10, 2, 7, -4, 4, 2'b10, 2'b00, 0);
    tbl[9]  = mk(2'b00, 2, 7, -4, 4, 2'b00, 2'b10, -16);
    tbl[10] = mk(2'b01, -16777216, -16777216, 0, 0, 2'b01, 2'b00, 0);
    tbl[11] = mk(2'b00, -16777216, -16777216, 0, 0, 2'b00, 2'b01, 64'sd1 <<< 48);

    // T1: reset held with both requests pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t1_gnt1_in_reset", gnt1, 0);
      chk("t1_gnt3_in_reset", gnt3, 0);
      chk("t1_rv1_in_reset", rv1, 0);
      chk("t1_rv3_in_reset", rv3, 0);
    end
    chk("t1_res1_reset", res1, 0);
    chk("t1_res3_reset", res3, 0);
    reset_n = 1'b1; #1;
    chk("t1_first_gnt", gnt1, 2'b01);
    req = 2'b00;

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt1, tbl[i].gnt);
      chk($sformatf("tbl%0d_rv", i), rv1, tbl[i].rv);
      chk($sformatf("tbl%0d_res", i), res1, tbl[i].res);
      @(negedge clk);
    end
    req = 2'b00;

    // T4: latency 3 on dut3
    do_reset();
    req = 2'b01; a0 = 25'sd8388608; b0 = 25'sd2; #1;
    chk("t4_gnt", gnt3, 2'b01);
    @(negedge clk);
    req = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("t4_rv_c%0d", k), rv3, (k == 3) ? 2'b01 : 2'b00);
      if (k == 3) chk("t4_res", res3, 64'sd16777216);
      @(negedge clk);
    end

    // T5: reset one cycle after a grant discards the in-flight product
    do_reset();
    req = 2'b01; a0 = 25'sd5; b0 = 25'sd5; #1;
    chk("t5_gnt", gnt3, 2'b01);
    @(negedge clk);
    req = 2'b00; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t5_no_rv_c%0d", k), rv3, 0);
      @(negedge clk);
    end

`ifdef MULT_ARB_LOCK_EN
    // T6: requester 0 holds the multiplier while lock[0] is set
    do_reset();
    req = 2'b11; lock = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_locked_gnt%0d", k), gnt1, 2'b01);
      @(negedge clk);
    end
    lock = 2'b00; req = 2'b10; #1;
    chk("t6_after_release", gnt1, 2'b10);
    @(negedge clk);
    req = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
